// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipeline memory arbiter.
//   WORD_W          - data/address width of the unified memory port
//   STREAK_W        - width of the fairness counter
//   STREAK_MAX_DEF  - default limit of consecutive data grants while a fetch waits
//   arb_state_t     - arbiter/sequencer states
package pipe_pkg;

    localparam int WORD_W         = 32;
    localparam int STREAK_W       = 4;
    localparam int STREAK_MAX_DEF = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,   // no access in flight
        DBUSY = 3'd1,   // data access waiting for mem_ready
        IBUSY = 3'd2,   // fetch access waiting for mem_ready
        DDONE = 3'd3,   // data completion cycle (m_done)
        IDONE = 3'd4    // fetch completion cycle (if_done)
    } arb_state_t;

endpackage

// File: rtl/pipememarb_streak.sv
// pipememarb_streak: saturating count of data grants issued while a fetch
// was pending. The arbiter uses 'sat' to force the next grant to fetch.
//   clock  - rising-edge clock
//   resetn - asynchronous active-low reset
//   inc    - a data grant happened with a fetch pending
//   clr    - a fetch grant happened (clr wins over inc)
//   sat    - count has reached STREAK_MAX
module pipememarb_streak
    import pipe_pkg::*;
#(
    parameter int STREAK_MAX = STREAK_MAX_DEF
) (
    input  logic clock,
    input  logic resetn,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    logic [STREAK_W-1:0] cnt;

    assign sat = (cnt == STREAK_W'(STREAK_MAX));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipememarb.sv
// pipememarb: arbiter/sequencer sharing one single-port memory between
// instruction fetch and the MEM stage of a 5-stage pipeline.
//   clock, resetn            - rising-edge clock, async active-low reset
//   if_req/if_addr           - fetch request (held until if_done) and address
//   if_rdata/if_done         - registered fetch data, one-cycle completion pulse
//   mwmem/mm2reg/malu/mb     - MEM-stage store/load, address, store data
//   m_rdata/m_done           - registered load data, one-cycle completion pulse
//   stall                    - freezes PC and pipeline registers while waiting
//   mem_req/we/addr/wdata    - memory request side (from latched registers)
//   mem_rdata/mem_ready      - memory response, ready is a one-cycle strobe
module pipememarb
    import pipe_pkg::*;
#(
    parameter int STREAK_MAX = STREAK_MAX_DEF
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              if_req,
    input  logic [WORD_W-1:0] if_addr,
    output logic [WORD_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              mwmem,
    input  logic              mm2reg,
    input  logic [WORD_W-1:0] malu,
    input  logic [WORD_W-1:0] mb,
    output logic [WORD_W-1:0] m_rdata,
    output logic              m_done,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    arb_state_t        state, state_nx;
    logic              d_req;
    logic              can_d, can_i;
    logic              grant_d, grant_i;
    logic              sat;
    logic              busy;
    logic [WORD_W-1:0] addr_q, wdata_q;
    logic              we_q;

    // A store takes precedence when both MEM-stage controls are high.
    assign d_req = mwmem | mm2reg;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next state and grants. Arbitration happens in IDLE and both DONE
    // states; a DONE state never re-grants the requester it just served,
    // because that requester's request is still high during its done cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        can_d    = 1'b0;
        can_i    = 1'b0;
        grant_d  = 1'b0;
        grant_i  = 1'b0;
        case (state)
            IDLE, DDONE, IDONE: begin
                can_d = d_req  && (state != DDONE);
                can_i = if_req && (state != IDONE);
                // Data normally wins; fetch wins once the streak limit is hit.
                if (can_i && sat) begin
                    grant_i = 1'b1;
                end else if (can_d) begin
                    grant_d = 1'b1;
                end else if (can_i) begin
                    grant_i = 1'b1;
                end
                if (grant_d) begin
                    state_nx = DBUSY;
                end else if (grant_i) begin
                    state_nx = IBUSY;
                end else begin
                    state_nx = IDLE;
                end
            end
            DBUSY: begin
                if (mem_ready) begin
                    state_nx = DDONE;
                end
            end
            IBUSY: begin
                if (mem_ready) begin
                    state_nx = IDONE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch: the memory sees the values captured at grant time, so
    // upstream changes during BUSY cannot disturb the access.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else if (grant_d) begin
            addr_q  <= malu;
            wdata_q <= mb;
            we_q    <= mwmem;
        end else if (grant_i) begin
            addr_q  <= if_addr;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read data capture; a store completion leaves m_rdata untouched.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_rdata  <= '0;
            if_rdata <= '0;
        end else begin
            if (state == DBUSY && mem_ready && !we_q) begin
                m_rdata <= mem_rdata;
            end
            if (state == IBUSY && mem_ready) begin
                if_rdata <= mem_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Fairness counter
    // ------------------------------------------------------------------
    pipememarb_streak #(
        .STREAK_MAX (STREAK_MAX)
    ) u_streak (
        .clock  (clock),
        .resetn (resetn),
        .inc    (grant_d & if_req),
        .clr    (grant_i),
        .sat    (sat)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy      = (state == DBUSY) || (state == IBUSY);
    assign mem_req   = busy;
    assign mem_we    = we_q & busy;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign m_done    = (state == DDONE);
    assign if_done   = (state == IDONE);

    // The done cycle releases the stall so the pipeline advances exactly once.
    assign stall = (d_req & ~m_done) | (if_req & ~if_done);

endmodule

// File: tb/tb_pipememarb.sv
// tb_pipememarb: self-checking bench for pipememarb. Directed table of single
// transactions, hand-written multi-cycle sequences, then randomized traffic
// checked against a cycle-level behavioural reference model.
module tb_pipememarb;

    localparam int SMAX = 4;

    logic        clock = 1'b0;
    logic        resetn;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        mwmem, mm2reg;
    logic [31:0] malu, mb;
    logic [31:0] m_rdata;
    logic        m_done;
    logic        stall;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int checks = 0;
    int errors = 0;

    // directed memory responder settings
    int          dw_waits = 0;
    int          dw_cnt   = 0;
    logic [31:0] dw_rdata = '0;

    always #5 clock = ~clock;

    pipememarb #(.STREAK_MAX(SMAX)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .mwmem     (mwmem),
        .mm2reg    (mm2reg),
        .malu      (malu),
        .mb        (mb),
        .m_rdata   (m_rdata),
        .m_done    (m_done),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    typedef struct {
        bit          mw, mr, fe;
        logic [31:0] addr, wdata, rdata;
        int          waits, lat;
        bit          we;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Advance one cycle and answer a pending access after dw_waits wait states.
    task automatic tick();
        @(posedge clock);
        #2;
        if (mem_req) begin
            mem_ready = (dw_cnt == dw_waits);
            mem_rdata = mem_ready ? dw_rdata : 32'hBAD0BAD0;
            dw_cnt    = mem_ready ? 0 : dw_cnt + 1;
        end else begin
            mem_ready = 1'b0;
            dw_cnt    = 0;
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        if_req = 1'b0; mwmem = 1'b0; mm2reg = 1'b0;
        mem_ready = 1'b0; dw_cnt = 0;
        #3;
        resetn = 1'b1;
        tick();
    endtask

    // One isolated transaction from IDLE; done latency, bus fields and
    // returned data are compared with the record's expectations.
    task automatic do_xact(input vec_t v);
        int busy_n, lat;
        bit ok, got;
        dw_waits = v.waits; dw_rdata = v.rdata; dw_cnt = 0;
        if (v.fe) begin
            if_req = 1'b1; if_addr = v.addr;
        end else begin
            mwmem = v.mw; mm2reg = v.mr; malu = v.addr; mb = v.wdata;
        end
        #1 chkb("stall_on_request", stall, 1'b1);
        busy_n = 0; ok = 1'b1; got = 1'b0; lat = 0;
        for (int c = 1; c <= 20 && !got; c++) begin
            tick();
            if (mem_req) begin
                busy_n++;
                if (mem_we !== v.we || mem_addr !== v.addr || (v.we && mem_wdata !== v.wdata))
                    ok = 1'b0;
            end
            if (v.fe ? if_done : m_done) begin
                got = 1'b1; lat = c;
            end
        end
        chk("done_latency", lat, v.lat);
        chk("busy_cycles", busy_n, v.waits + 1);
        chkb("bus_fields_held", ok, 1'b1);
        chk("rdata", v.fe ? if_rdata : m_rdata, v.rd);
        #1 chkb("stall_released_at_done", stall, 1'b0);
        if_req = 1'b0; mwmem = 1'b0; mm2reg = 1'b0;
        tick();
        chk("quiet_after_done", {29'd0, mem_req, m_done, if_done}, 32'd0);
    endtask

    // ---------------- reference model state (random phase) ----------------
    int          ph;      // 0 free, 1 access in flight, 2 completion cycle
    int          own;     // 1 data, 2 fetch
    int          strk;
    int          wleft;
    logic [31:0] la, lw, erm, eri;
    bit          lwe;
    logic [31:0] memv [logic [31:0]];

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        return memv.exists(a) ? memv[a] : (a ^ 32'h5A5A0000);
    endfunction

    initial begin
        int md, id, k;
        bit mdn, idn, dq, cd, ci;

        resetn = 1'b0;
        if_req = 1'b0; if_addr = '0;
        mwmem = 1'b0; mm2reg = 1'b0; malu = '0; mb = '0;
        mem_rdata = '0; mem_ready = 1'b0;

        //              mw    mr    fe    addr          wdata         rdata        wt lat we    rd
        tbl[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 0, 2, 1'b0, 32'hDEADBEEF};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h12345678, 32'h0,        3, 5, 1'b1, 32'hDEADBEEF};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_0044, 32'hAAAA5555, 32'h0,        1, 3, 1'b1, 32'hDEADBEEF};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 32'h0000_0400, 32'h0,        32'h00000013, 0, 2, 1'b0, 32'h00000013};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 32'h0000_0404, 32'h0,        32'hCAFEF00D, 2, 4, 1'b0, 32'hCAFEF00D};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 32'h0000_0008, 32'h0,        32'h00000000, 1, 3, 1'b0, 32'h00000000};

        // ---------------- reset values ----------------
        #12;
        chkb("rst_mem_req", mem_req, 1'b0);
        chkb("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_m_rdata", m_rdata, 32'h0);
        chkb("rst_if_done", if_done, 1'b0);
        chkb("rst_m_done", m_done, 1'b0);
        chkb("rst_stall", stall, 1'b0);
        resetn = 1'b1;
        tick();

        // ---------------- table of single transactions ----------------
        for (int i = 0; i < 6; i++) do_xact(tbl[i]);

        // ---------------- simultaneous requests, zero wait ----------------
        dw_waits = 0; dw_rdata = 32'h11112222;
        mm2reg = 1'b1; malu = 32'h600; if_req = 1'b1; if_addr = 32'h500;
        md = 0; id = 0;
        for (int c = 1; c <= 12 && id == 0; c++) begin
            tick();
            if (c == 1) chk("simul_data_first", mem_addr, 32'h600);
            if (c == 3) chk("simul_fetch_second", mem_addr, 32'h500);
            if (m_done) begin md = c; mm2reg = 1'b0; end
            if (if_done) begin id = c; if_req = 1'b0; end
        end
        chk("simul_m_done_cycle", md, 2);
        chk("simul_if_done_cycle", id, 4);
        chk("simul_if_rdata", if_rdata, 32'h11112222);
        chk("simul_m_rdata", m_rdata, 32'h11112222);
        tick();

        // ---------------- reset during a data access ----------------
        dw_waits = 5; dw_rdata = 32'h55555555;
        mwmem = 1'b1; malu = 32'h300; mb = 32'hFEEDFACE;
        tick(); tick();
        chkb("midrst_busy", mem_req, 1'b1);
        chkb("midrst_busy_we", mem_we, 1'b1);
        resetn = 1'b0;
        #1;
        chkb("midrst_mem_req", mem_req, 1'b0);
        chkb("midrst_mem_we", mem_we, 1'b0);
        chk("midrst_mem_addr", mem_addr, 32'h0);
        chk("midrst_mem_wdata", mem_wdata, 32'h0);
        chk("midrst_m_rdata", m_rdata, 32'h0);
        chk("midrst_if_rdata", if_rdata, 32'h0);
        chkb("midrst_m_done", m_done, 1'b0);
        mwmem = 1'b0;
        tick();
        resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("midrst_no_stale", {30'd0, m_done, mem_req}, 32'd0);
        end
        do_xact('{1'b0, 1'b1, 1'b0, 32'h304, 32'h0, 32'h0BADCAFE, 0, 2, 1'b0, 32'h0BADCAFE});

        // ---------------- starvation guard ----------------
        // A legal requester always gets its fetch in from DDONE, so the fetch
        // request is withdrawn while each data access is in flight; that
        // lets data grants with a fetch pending accumulate to the limit.
        do_reset();
        dw_waits = 0;
        for (int r = 0; r < SMAX; r++) begin
            dw_rdata = 32'h100 + 32'(r);
            mm2reg = 1'b1; malu = 32'h700 + 32'(r * 4); if_req = 1'b1; if_addr = 32'h900;
            tick();
            chk("starve_data_wins", mem_addr, 32'h700 + 32'(r * 4));
            if_req = 1'b0;
            tick();
            chkb("starve_m_done", m_done, 1'b1);
            mm2reg = 1'b0;
            tick();
        end
        mm2reg = 1'b1; malu = 32'h7F0; if_req = 1'b1; if_addr = 32'h900;
        tick();
        chk("starve_fetch_forced", mem_addr, 32'h900);
        chkb("starve_fetch_read", mem_we, 1'b0);
        tick();
        chkb("starve_if_done", if_done, 1'b1);
        if_req = 1'b0;
        tick();
        chk("starve_data_after_fetch", mem_addr, 32'h7F0);
        tick();
        mm2reg = 1'b0;
        tick();
        mm2reg = 1'b1; malu = 32'h7F4; if_req = 1'b1;
        tick();
        chk("starve_streak_cleared", mem_addr, 32'h7F4);
        if_req = 1'b0;
        tick();
        mm2reg = 1'b0;
        tick();

        // ---------------- randomized traffic vs reference model ----------------
        do_reset();
        ph = 0; own = 0; strk = 0; wleft = 0; la = '0; lw = '0; lwe = 1'b0;
        erm = '0; eri = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clock);
            #2;
            mdn = (ph == 2 && own == 1);
            idn = (ph == 2 && own == 2);
            chkb("r_mem_req", mem_req, ph == 1);
            if (ph == 1) begin
                chk("r_mem_addr", mem_addr, la);
                chkb("r_mem_we", mem_we, lwe);
                if (lwe) chk("r_mem_wdata", mem_wdata, lw);
            end
            chkb("r_m_done", m_done, mdn);
            chkb("r_if_done", if_done, idn);
            chk("r_m_rdata", m_rdata, erm);
            chk("r_if_rdata", if_rdata, eri);

            // requesters change only when idle or in their done cycle
            if (mdn || (!(mwmem | mm2reg) && $urandom_range(0, 2) == 0)) begin
                if ($urandom_range(0, 1) == 1) begin
                    k = $urandom_range(0, 4);
                    mwmem  = (k == 0 || k == 4);
                    mm2reg = (k != 0);
                    malu   = $urandom & 32'h3C;
                    mb     = $urandom;
                end else begin
                    mwmem = 1'b0; mm2reg = 1'b0;
                end
            end
            if (idn || (!if_req && $urandom_range(0, 2) == 0)) begin
                if_req  = ($urandom_range(0, 1) == 1);
                if_addr = $urandom & 32'h3C;
            end

            // memory: random wait states; stray ready pulses while not busy
            if (ph == 1) begin
                mem_ready = (wleft == 0);
                if (wleft > 0) wleft--;
                mem_rdata = (mem_ready && !lwe) ? rd_val(la) : $urandom;
            end else begin
                mem_ready = ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end

            dq = mwmem | mm2reg;
            #1 chkb("r_stall", stall, (dq && !mdn) || (if_req && !idn));

            // model advance to the next cycle
            if (ph == 1) begin
                if (mem_ready) begin
                    if (own == 1 && !lwe) erm = mem_rdata;
                    if (own == 2) eri = mem_rdata;
                    if (lwe) memv[la] = lw;
                    ph = 2;
                end
            end else begin
                cd = dq && !mdn;
                ci = if_req && !idn;
                if (ci && (strk == SMAX || !cd)) begin
                    strk = 0; la = if_addr; lwe = 1'b0; own = 2; ph = 1;
                    wleft = $urandom_range(0, 3);
                end else if (cd) begin
                    if (if_req && strk < SMAX) strk++;
                    la = malu; lw = mb; lwe = mwmem; own = 1; ph = 1;
                    wleft = $urandom_range(0, 3);
                end else begin
                    ph = 0;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
